// File: rtl/sync_fifo_param.sv
// sync_fifo_param: synchronous FIFO with count, threshold flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is a registered read port.
module sync_fifo_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int AF_LVL = (2 ** ADDR_W) - 2,
    parameter int AE_LVL = 2
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic              WR,
    input  logic [DATA_W-1:0] WR_DATA,
    input  logic              RD,
    input  logic              CLR_ERR,
    output logic [DATA_W-1:0] RD_DATA,
    output logic              FULL,
    output logic              EMPTY,
    output logic              ALMOST_FULL,
    output logic              ALMOST_EMPTY,
    output logic [ADDR_W:0]   COUNT,
    output logic              OVERFLOW,
    output logic              UNDERFLOW
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C = (ADDR_W + 1)'(AF_LVL);
    localparam logic [ADDR_W:0] AE_C = (ADDR_W + 1)'(AE_LVL);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [DATA_W-1:0] data_q;
    logic wr_ok, rd_ok;
    assign FULL = COUNT == DEPTH_C;
    assign EMPTY = COUNT == '0;
    assign ALMOST_FULL = COUNT >= AF_C;
    assign ALMOST_EMPTY = COUNT <= AE_C;
    // a full FIFO still takes a write when a read frees the slot on the same edge
    assign wr_ok = WR && (!FULL || RD);
    assign rd_ok = RD && !EMPTY;
    always_ff @(posedge i_CLK) begin
        if (wr_ok && !i_RST) mem[wr_ptr] <= WR_DATA;
    end
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            COUNT <= '0;
            data_q <= '0;
            OVERFLOW <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_ok) rd_ptr <= rd_ptr + ADDR_W'(1);
            if (rd_ok) data_q <= mem[rd_ptr];
            COUNT <= COUNT + (ADDR_W + 1)'(wr_ok) - (ADDR_W + 1)'(rd_ok);
            OVERFLOW <= (WR && !RD && FULL) || (OVERFLOW && !CLR_ERR);
            UNDERFLOW <= (RD && EMPTY) || (UNDERFLOW && !CLR_ERR);
        end
    end
`ifdef SYNC_FIFO_FWFT_EN
    // data_q captures the word being popped, so it shows the last word once empty
    assign RD_DATA = EMPTY ? data_q : mem[rd_ptr];
`else
    assign RD_DATA = data_q;
`endif
endmodule
